multi_mode_router: RTL and testbench
====================================

Name: multi_mode_router

Overview:
- Parametrised successor to the fixed three-mode clock top. Selects one of N_MODES application sub-blocks (watch, stopwatch, timer, alarm, ...).
- Routes debounced button pulses to the selected sub-block only, and muxes that sub-block's display value to the FND driver.
- Adds bidirectional mode stepping, an idle auto-return to a home mode, and a status timeout pulse.
- Sits between the button_cntr instances and the application sub-blocks / fnd_4digit_cntr.

Parameters:
- N_MODES, 3, number of application modes (2..15).
- N_BTN, 4, function buttons routed per mode.
- VAL_W, 16, display value width per mode (>=8).
- HOME_MODE, 0, mode index entered at reset and on idle timeout (< N_MODES).
- TIMEOUT_TICKS, 30, idle ticks before auto-return; 0 disables auto-return.
- BANNER_TICKS, 2, ticks the mode banner is shown (only with MODE_BANNER_EN).

Ports:
- clk, input, 1, system clock.
- reset_p, input, 1, asynchronous, active-high reset.
- tick, input, 1, one-cycle timebase pulse (1 Hz in system use).
- btn_next, input, 1, one-cycle pulse: step to next mode.
- btn_prev, input, 1, one-cycle pulse: step to previous mode.
- btn_pe, input, N_BTN, one-cycle function-button pulses.
- sub_value, input, N_MODES*VAL_W, packed display values; mode m occupies bits [m*VAL_W +: VAL_W].
- sub_busy, input, N_MODES, mode m is running (stopwatch or timer counting); inhibits auto-return.
- sub_btn, output, N_MODES*N_BTN, routed button pulses; mode m occupies bits [m*N_BTN +: N_BTN].
- value, output, VAL_W, registered display value.
- mode_idx, output, $clog2(N_MODES) (min 1), current mode index.
- mode_onehot, output, N_MODES, one-hot form of mode_idx.
- timeout_evt, output, 1, one-cycle pulse on auto-return.
- banner_active, output, 1, banner is being displayed.

Behaviour:
- Reset, asynchronous: mode_idx=HOME_MODE; value=0; timeout_evt=0; banner_active=0; idle counter=0.
- Mode register:
  - btn_next only: mode_idx is updated on the next edge; it wraps from N_MODES-1 to 0.
  - btn_prev only: mode_idx is decremented; it wraps from 0 to N_MODES-1.
  - btn_next and btn_prev in the same cycle: no change.
  - Button mode change has priority over a timeout falling in the same cycle. The timeout is discarded and the idle counter is cleared.
- mode_onehot = 1 << mode_idx, combinational from the register.
- Routing is combinational from the current mode_idx:
  - sub_btn slice[mode_idx] = btn_pe; all other slices are 0.
  - A btn_pe pulse coincident with a mode step goes to the old mode. No pulse is dropped or duplicated.
- value is registered: value <= sub_value slice[mode_idx]. Latency is 1 cycle from sub_value or a mode change.
- Idle counter, width covers TIMEOUT_TICKS:
  - Cleared on any btn_pe bit, btn_next, btn_prev, or auto-return.
  - Cleared while mode_idx==HOME_MODE or sub_busy[mode_idx]==1.
  - Otherwise it increments on tick.
  - When tick occurs with the counter at TIMEOUT_TICKS-1: mode_idx<=HOME_MODE, timeout_evt=1 for exactly that cycle, and the counter is cleared.
- TIMEOUT_TICKS==0: counter held at 0; timeout_evt never asserts.
- Mid-operation reset returns to HOME_MODE immediately, regardless of the counter or busy state.

Optional Feature:
- MODE_BANNER_EN defined:
  - Every mode change (button or timeout) sets banner_active on the same edge that updates mode_idx, and clears a banner tick counter.
  - While banner_active: value = {(VAL_W-4)'b0, mode_idx+1}.
  - banner_active clears on the BANNER_TICKS-th tick after the change, or on any btn_pe (that btn_pe is still routed). value resumes the mux on the following cycle.
  - A new mode change during the banner restarts the banner.
- MODE_BANNER_EN undefined: banner_active tied 0; the banner logic is absent.

Decomposition:
- Shared package mode_pkg: localparams for the system mode indices (MODE_WATCH=0, MODE_STOPWATCH=1, MODE_TIMER=2); a function for the mode_idx width; the banner value format constant.
- Sub-module idle_timer: tick-driven counter with clear, enable and terminal-count pulse (parameter TICKS). It is instantiated once for the idle timeout, and a second time for the banner when MODE_BANNER_EN is defined.

Test Plan:
1. Reset, then 3 btn_next pulses, N_MODES=3 -> mode_idx 1, 2, 0; mode_onehot 010, 100, 001; value tracks slices with 1-cycle lag.
2. btn_prev from mode 0 -> mode 2; btn_next and btn_prev in the same cycle -> mode unchanged.
3. Mode 1, btn_pe=4'b0101 -> sub_btn[7:4]=0101, other slices 0. Pulse coincident with btn_next -> delivered to mode 1, then mode=2.
4. TIMEOUT_TICKS=3, mode 2, no buttons, 3 ticks -> timeout_evt pulses on the 3rd tick and mode=0. Repeat with sub_busy[2]=1 -> no return after 10 ticks.
5. Timeout tick and btn_next in the same cycle, mode 1 -> mode 2, no timeout_evt. TIMEOUT_TICKS=0 -> never returns.
6. MODE_BANNER_EN, BANNER_TICKS=2, step to mode 1 -> value=16'h0002 and banner_active=1 until the 2nd tick. A btn_pe mid-banner ends it one cycle later.

Source files
------------

// File: rtl/mode_pkg.sv
// Shared definitions for the multi-mode clock router: system mode indices,
// the mode index width helper, and the mode banner format.
package mode_pkg;

    localparam int MODE_WATCH     = 0;
    localparam int MODE_STOPWATCH = 1;
    localparam int MODE_TIMER     = 2;

    // The banner shows the 1-based mode number in the low nibble of the display.
    localparam int BANNER_W = 4;

    // The mode index is always at least one bit wide, even for two modes.
    function automatic int mode_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [BANNER_W-1:0] banner_code(input int idx);
        return BANNER_W'(idx + 1);
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Tick-driven up-counter with synchronous clear and enable. tc pulses
// combinationally on the tick that would take the count to TICKS, and the
// count restarts from zero. TICKS == 0 holds the counter at zero and never
// raises tc.
module idle_timer #(
    parameter int TICKS = 30
) (
    input  logic clk,
    input  logic reset_p,
    input  logic tick,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TICKS < 1) ? 1 : $clog2(TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'((TICKS < 1) ? 0 : TICKS - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count and terminal-count pulse.
    always_comb begin
        count_d = count_q;
        tc      = 1'b0;
        if (TICKS == 0 || clr || !en) begin
            count_d = '0;
        end else if (tick) begin
            if (count_q == LAST) begin
                tc      = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multi_mode_router.sv
// Mode router for the multi-mode clock: holds the current mode, routes
// function-button pulses to the selected sub-block, registers that
// sub-block's display value, and returns to HOME_MODE after an idle period.
// Optional feature macro: MODE_BANNER_EN (shows the 1-based mode number for
// BANNER_TICKS ticks after every mode change).
module multi_mode_router
    import mode_pkg::*;
#(
    parameter int N_MODES       = 3,
    parameter int N_BTN         = 4,
    parameter int VAL_W         = 16,
    parameter int HOME_MODE     = MODE_WATCH,
    parameter int TIMEOUT_TICKS = 30,
    parameter int BANNER_TICKS  = 2
) (
    input  logic                         clk,
    input  logic                         reset_p,
    input  logic                         tick,
    input  logic                         btn_next,
    input  logic                         btn_prev,
    input  logic [N_BTN-1:0]             btn_pe,
    input  logic [N_MODES*VAL_W-1:0]     sub_value,
    input  logic [N_MODES-1:0]           sub_busy,
    output logic [N_MODES*N_BTN-1:0]     sub_btn,
    output logic [VAL_W-1:0]             value,
    output logic [mode_w(N_MODES)-1:0]   mode_idx,
    output logic [N_MODES-1:0]           mode_onehot,
    output logic                         timeout_evt,
    output logic                         banner_active
);

    localparam int MW = mode_w(N_MODES);
    localparam logic [MW-1:0] LAST_MODE = MW'(N_MODES - 1);
    localparam logic [MW-1:0] HOME      = MW'(HOME_MODE);

    logic [MW-1:0]    mode_q, mode_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic             timeout_q, timeout_d;

    logic             cur_busy;
    logic [VAL_W-1:0] cur_value;
    logic             step_next, step_prev;
    logic             btn_activity;
    logic             idle_tc;
    logic             mode_change;

    // Per-mode selection: routing, one-hot decode, busy and value of the current mode.
    always_comb begin
        cur_busy    = 1'b0;
        cur_value   = '0;
        sub_btn     = '0;
        mode_onehot = '0;
        for (int m = 0; m < N_MODES; m++) begin
            if (mode_q == MW'(m)) begin
                cur_busy                   = sub_busy[m];
                cur_value                  = sub_value[m*VAL_W +: VAL_W];
                sub_btn[m*N_BTN +: N_BTN]  = btn_pe;
                mode_onehot[m]             = 1'b1;
            end
        end
    end

    assign btn_activity = (|btn_pe) | btn_next | btn_prev;

    // Idle timeout only runs away from home while the current sub-block is not busy.
    idle_timer #(
        .TICKS (TIMEOUT_TICKS)
    ) u_idle (
        .clk     (clk),
        .reset_p (reset_p),
        .tick    (tick),
        .clr     (btn_activity),
        .en      ((mode_q != HOME) && !cur_busy),
        .tc      (idle_tc)
    );

    // Next mode: button steps win over the idle timeout; next+prev together cancel.
    always_comb begin
        step_next = btn_next & ~btn_prev;
        step_prev = btn_prev & ~btn_next;
        mode_d    = mode_q;
        if (step_next) begin
            mode_d = (mode_q == LAST_MODE) ? '0 : mode_q + MW'(1);
        end else if (step_prev) begin
            mode_d = (mode_q == '0) ? LAST_MODE : mode_q - MW'(1);
        end else if (idle_tc) begin
            mode_d = HOME;
        end
        mode_change = step_next | step_prev | idle_tc;
        timeout_d   = idle_tc;
    end

`ifdef MODE_BANNER_EN
    logic banner_q, banner_d;
    logic banner_tc;

    // Banner duration counter, restarted by every mode change.
    idle_timer #(
        .TICKS (BANNER_TICKS)
    ) u_banner (
        .clk     (clk),
        .reset_p (reset_p),
        .tick    (tick),
        .clr     (mode_change),
        .en      (banner_q),
        .tc      (banner_tc)
    );

    // Banner flag and display value; a mode change outranks a clearing event.
    always_comb begin
        banner_d = banner_q;
        if (mode_change) begin
            banner_d = 1'b1;
        end else if (banner_tc || (|btn_pe)) begin
            banner_d = 1'b0;
        end
        value_d = banner_d ? {{(VAL_W-BANNER_W){1'b0}}, banner_code(int'(mode_d))} : cur_value;
    end

    // Banner flag register.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            banner_q <= 1'b0;
        end else begin
            banner_q <= banner_d;
        end
    end

    assign banner_active = banner_q;
`else
    // Display value is the current mode's slice, one cycle late.
    always_comb begin
        value_d = cur_value;
    end

    assign banner_active = 1'b0;
`endif

    // Mode, display value and timeout pulse registers.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            mode_q    <= HOME;
            value_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            value_q   <= value_d;
            timeout_q <= timeout_d;
        end
    end

    assign mode_idx    = mode_q;
    assign value       = value_q;
    assign timeout_evt = timeout_q;

endmodule

// File: tb/tb_multi_mode_router.sv
// Bench for multi_mode_router: table of one-cycle vectors with a value
// scoreboard, plus hand-written reset, latency, timeout-disabled and banner
// sequences. A second instance runs with the idle timeout disabled.
module tb_multi_mode_router;

    localparam int N_MODES = 3;
    localparam int N_BTN   = 4;
    localparam int VAL_W   = 16;

    logic                       clk = 1'b0;
    logic                       reset_p = 1'b1;
    logic                       tick = 1'b0;
    logic                       btn_next = 1'b0;
    logic                       btn_prev = 1'b0;
    logic [N_BTN-1:0]           btn_pe = '0;
    logic [N_MODES*VAL_W-1:0]   sub_value;
    logic [N_MODES-1:0]         sub_busy = '0;

    logic [N_MODES*N_BTN-1:0]   sub_btn, sub_btn0;
    logic [VAL_W-1:0]           value, value0;
    logic [1:0]                 mode_idx, mode_idx0;
    logic [N_MODES-1:0]         mode_onehot, mode_onehot0;
    logic                       timeout_evt, timeout_evt0;
    logic                       banner_active, banner_active0;

    logic [VAL_W-1:0] vals [N_MODES] = '{16'hA5A0, 16'h5A51, 16'h3C32};

    int checks   = 0;
    int failures = 0;
    bit seen_to0 = 1'b0;
    int model_mode = 0;
    logic [VAL_W-1:0] exp_q[$];

    always #5 clk = ~clk;
    always_comb sub_value = {vals[2], vals[1], vals[0]};

    multi_mode_router #(
        .N_MODES(N_MODES), .N_BTN(N_BTN), .VAL_W(VAL_W), .HOME_MODE(0),
        .TIMEOUT_TICKS(3), .BANNER_TICKS(2)
    ) u_dut (
        .clk(clk), .reset_p(reset_p), .tick(tick), .btn_next(btn_next),
        .btn_prev(btn_prev), .btn_pe(btn_pe), .sub_value(sub_value),
        .sub_busy(sub_busy), .sub_btn(sub_btn), .value(value),
        .mode_idx(mode_idx), .mode_onehot(mode_onehot),
        .timeout_evt(timeout_evt), .banner_active(banner_active)
    );

    multi_mode_router #(
        .N_MODES(N_MODES), .N_BTN(N_BTN), .VAL_W(VAL_W), .HOME_MODE(0),
        .TIMEOUT_TICKS(0), .BANNER_TICKS(2)
    ) u_dut0 (
        .clk(clk), .reset_p(reset_p), .tick(tick), .btn_next(btn_next),
        .btn_prev(btn_prev), .btn_pe(btn_pe), .sub_value(sub_value),
        .sub_busy(sub_busy), .sub_btn(sub_btn0), .value(value0),
        .mode_idx(mode_idx0), .mode_onehot(mode_onehot0),
        .timeout_evt(timeout_evt0), .banner_active(banner_active0)
    );

    always @(negedge clk) if (timeout_evt0) seen_to0 = 1'b1;

    typedef struct {
        bit                     nxt;
        bit                     prv;
        logic [N_BTN-1:0]       pe;
        bit                     tk;
        logic [N_MODES-1:0]     busy;
        logic [N_MODES*N_BTN-1:0] exp_sb;
        int                     exp_mode;
        bit                     exp_to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit n, bit p, logic [3:0] pe, bit t, logic [2:0] b,
                                logic [11:0] sb, int m, bit to);
        vec_t v;
        v.nxt = n; v.prv = p; v.pe = pe; v.tk = t; v.busy = b;
        v.exp_sb = sb; v.exp_mode = m; v.exp_to = to;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [VAL_W-1:0] exp_v;
        @(negedge clk);
        btn_next = v.nxt; btn_prev = v.prv; btn_pe = v.pe; tick = v.tk; sub_busy = v.busy;
        #1;
        check($sformatf("sub_btn[%0d]", idx), 32'(sub_btn), 32'(v.exp_sb));
        exp_q.push_back(vals[model_mode]);
        @(posedge clk);
        #1;
        btn_next = 1'b0; btn_prev = 1'b0; btn_pe = '0; tick = 1'b0; sub_busy = '0;
        model_mode = v.exp_mode;
        check($sformatf("mode[%0d]", idx), 32'(mode_idx), 32'(v.exp_mode));
        check($sformatf("onehot[%0d]", idx), 32'(mode_onehot), 32'(3'b001 << v.exp_mode));
        check($sformatf("timeout[%0d]", idx), 32'(timeout_evt), 32'(v.exp_to));
        exp_v = exp_q.pop_front();
`ifndef MODE_BANNER_EN
        check($sformatf("value[%0d]", idx), 32'(value), 32'(exp_v));
`endif
    endtask

    task automatic pulse(input bit n, input bit p, input logic [3:0] pe, input bit t);
        @(negedge clk);
        btn_next = n; btn_prev = p; btn_pe = pe; tick = t;
        @(posedge clk);
        #1;
        btn_next = 1'b0; btn_prev = 1'b0; btn_pe = '0; tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Stepping, wrap, simultaneous buttons, routing.
        tbl.push_back(mk(1,0,4'h0,0,3'b000,12'h000,1,0));
        tbl.push_back(mk(1,0,4'h0,0,3'b000,12'h000,2,0));
        tbl.push_back(mk(1,0,4'h0,0,3'b000,12'h000,0,0));
        tbl.push_back(mk(0,1,4'h0,0,3'b000,12'h000,2,0));
        tbl.push_back(mk(1,1,4'h0,0,3'b000,12'h000,2,0));
        tbl.push_back(mk(0,1,4'h0,0,3'b000,12'h000,1,0));
        tbl.push_back(mk(0,0,4'h5,0,3'b000,12'h050,1,0));
        tbl.push_back(mk(1,0,4'h3,0,3'b000,12'h030,2,0));
        // Idle return after three ticks.
        tbl.push_back(mk(0,0,4'h0,1,3'b000,12'h000,2,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b000,12'h000,2,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b000,12'h000,0,1));
        tbl.push_back(mk(0,0,4'h0,0,3'b000,12'h000,0,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b000,12'h000,0,0));
        // Busy current mode inhibits; busy elsewhere does not.
        tbl.push_back(mk(1,0,4'h0,0,3'b000,12'h000,1,0));
        tbl.push_back(mk(1,0,4'h0,0,3'b000,12'h000,2,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b100,12'h000,2,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b100,12'h000,2,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b100,12'h000,2,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b010,12'h000,2,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b000,12'h000,2,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b000,12'h000,0,1));
        // Timeout tick coincident with btn_next; btn_pe clears the idle count.
        tbl.push_back(mk(1,0,4'h0,0,3'b000,12'h000,1,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b000,12'h000,1,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b000,12'h000,1,0));
        tbl.push_back(mk(1,0,4'h0,1,3'b000,12'h000,2,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b000,12'h000,2,0));
        tbl.push_back(mk(0,0,4'h8,1,3'b000,12'h800,2,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b000,12'h000,2,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b000,12'h000,2,0));
        tbl.push_back(mk(0,0,4'h0,1,3'b000,12'h000,0,1));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_mode", 32'(mode_idx), 32'd0);
        check("rst_onehot", 32'(mode_onehot), 32'b001);
        check("rst_value", 32'(value), 32'd0);
        check("rst_timeout", 32'(timeout_evt), 32'd0);
        check("rst_banner", 32'(banner_active), 32'd0);
        @(negedge clk);
        reset_p = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

`ifndef MODE_BANNER_EN
        // One-cycle latency from a sub_value change.
        @(posedge clk);
        #1;
        check("val_settle", 32'(value), 32'(vals[0]));
        @(negedge clk);
        vals[0] = 16'hBEEF;
        #1;
        check("val_lag_before", 32'(value), 32'hA5A0);
        @(posedge clk);
        #1;
        check("val_lag_after", 32'(value), 32'hBEEF);
`endif

        // Asynchronous mid-operation reset.
        pulse(1, 0, 4'h0, 0);
        check("pre_rst_mode", 32'(mode_idx), 32'd1);
        @(negedge clk);
        #2 reset_p = 1'b1;
        #1;
        check("async_rst_mode", 32'(mode_idx), 32'd0);
        check("async_rst_value", 32'(value), 32'd0);
        @(negedge clk);
        reset_p = 1'b0;

        // Timeout disabled instance never returns.
        pulse(1, 0, 4'h0, 0);
        for (int i = 0; i < 10; i++) pulse(0, 0, 4'h0, 1);
        check("to3_returned", 32'(mode_idx), 32'd0);
        check("to0_mode", 32'(mode_idx0), 32'd1);
        check("to0_no_evt", 32'(seen_to0), 32'd0);

`ifdef MODE_BANNER_EN
        // Banner after a step, cleared by ticks, then by a function button.
        pulse(1, 0, 4'h0, 0);
        check("bn_active", 32'(banner_active), 32'd1);
        check("bn_value", 32'(value), 32'h0002);
        pulse(0, 0, 4'h0, 1);
        check("bn_tick1", 32'(banner_active), 32'd1);
        pulse(0, 0, 4'h0, 1);
        check("bn_tick2", 32'(banner_active), 32'd0);
        check("bn_resume", 32'(value), 32'(vals[1]));
        pulse(1, 0, 4'h0, 0);
        check("bn2_active", 32'(banner_active), 32'd1);
        check("bn2_value", 32'(value), 32'h0003);
        pulse(0, 0, 4'h1, 0);
        check("bn2_pe_clear", 32'(banner_active), 32'd0);
        check("bn2_resume", 32'(value), 32'(vals[2]));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
